ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, beats per fetch burst; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter DEPTH, default 8, instruction-buffer entries; power of 2 and at least BURST_LEN.
REQ-003 SHALL have parameter RESET_PC, default 32'h3000_0000, first fetch address after reset.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports are named clk_i and rst_i.
REQ-005 SHALL have ports, in this order:
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous active-high reset.
- redirect_i, in, 1: flush and restart fetch (from WBU).
- redirect_pc_i, in, 32: restart address.
- inst_o, out, 32: head instruction.
- pc_o, out, 32: head instruction address.
- valid_o, out, 1: head entry valid (to IDU).
- ready_i, in, 1: IDU accepts the head entry.
- arid_o, out, 4: read ID.
- araddr_o, out, 32: read address.
- arlen_o, out, 8: burst length.
- arsize_o, out, 3: transfer size.
- arburst_o, out, 2: burst type.
- arvalid_o, out, 1: read-address valid.
- arready_i, in, 1: read-address ready.
- rid_i, in, 4: read ID.
- rdata_i, in, 32: read data.
- rresp_i, in, 2: read response.
- rlast_i, in, 1: last beat.
- rvalid_i, in, 1: read-data valid.
- rready_o, out, 1: read-data ready.
- err_o, out, 1: sticky fetch error.

Function
REQ-006 SHALL drive arid_o=0, arsize_o=3'b010, arburst_o=2'b01 (INCR) as constants.
REQ-007 SHALL hold fetch_pc register, word aligned; off = fetch_pc[log2(BURST_LEN)+1:2]; beats = BURST_LEN-off, so no burst crosses a BURST_LEN*4-byte boundary.
REQ-008 SHALL implement FSM IDLE, REQ, DATA, DRAIN; reset state IDLE.
REQ-009 IDLE: go to REQ when free entries >= beats, redirect_i=0 and err_o=0; otherwise stay.
REQ-010 REQ: arvalid_o=1, araddr_o=fetch_pc, arlen_o=beats-1; on arvalid_o&arready_i go to DATA; araddr_o/arlen_o stable while arvalid_o=1; araddr_o=0, arlen_o=0 outside REQ.
REQ-011 DATA: rready_o=1; each beat pushes {fetch_pc, rdata_i} and sets fetch_pc += 4; on beat with rlast_i go to IDLE.
REQ-012 Redirect SHALL empty the buffer at the clock edge and load fetch_pc=redirect_pc_i: IDLE stays IDLE; REQ keeps arvalid_o asserted until handshake, then DRAIN; DATA goes to DRAIN, or IDLE if that cycle is the rlast beat.
REQ-013 DRAIN: rready_o=1; beats are discarded without push or fetch_pc change; on rlast beat go to IDLE.
REQ-014 valid_o SHALL equal buffer non-empty; inst_o/pc_o = head entry when valid_o=1, else 0; valid_o&ready_i pops.
REQ-015 Push and pop in one cycle SHALL both occur; redirect with pop or push SHALL leave the buffer empty (flush wins).
REQ-016 Buffer full and buffer empty SHALL be exact via DEPTH-wide count; pointers wrap modulo DEPTH; no overflow is possible because IDLE reserves space.
REQ-017 Latency: redirect at edge t gives arvalid_o=1 in cycle t+1 (if idle); an R beat at edge t gives valid_o=1 in cycle t+1.
REQ-018 rid_i SHALL be ignored.

Reset
REQ-019 rst_i=1 at an edge: state IDLE, fetch_pc=RESET_PC, buffer empty, err_o=0; so valid_o, arvalid_o, rready_o=0 and inst_o, pc_o=0.
REQ-020 Reset mid-burst SHALL abandon the transaction; the bench resets the slave too.

Configuration
REQ-021 Macro IFU_PREFETCH_RRESP_CHECK_EN defined: a non-discarded beat with rresp_i[1]=1 is not pushed, sets err_o=1 sticky until reset, and IDLE issues no further requests; redirect does not clear err_o.
REQ-022 Macro undefined: rresp_i is ignored, err_o is constant 0, and all beats are treated as OKAY.

Verification
REQ-023 Reset release, arready_i=1, slave returns 4 beats after 2 cycles -> araddr_o=0x3000_0000, arlen_o=3, pc_o sequence 0x3000_0000..0x3000_000C.
REQ-024 Redirect to 0x3000_0008 with BURST_LEN=4 -> arlen_o=1, two beats, pc_o 0x3000_0008 then 0x3000_000C.
REQ-025 ready_i=0 with DEPTH=8 -> exactly two bursts, valid_o held, no third arvalid_o until ready_i pops 4 entries.
REQ-026 Redirect during DATA beat 2 -> remaining beats consumed with rready_o=1 and discarded, next araddr_o=redirect_pc_i, no stale pc_o seen.
REQ-027 Redirect while arvalid_o=1 and arready_i=0 -> arvalid_o and araddr_o held until handshake, then DRAIN, then new request.
REQ-028 With IFU_PREFETCH_RRESP_CHECK_EN, beat 3 rresp_i=2'b10 -> err_o=1 next cycle, 2 entries buffered, no further arvalid_o.

Source files
------------

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch unit. It fetches aligned AXI read bursts
// from fetch_pc into a DEPTH-entry {pc, inst} FIFO and presents the head entry
// to the decoder.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   redirect_i, redirect_pc_i    flush the buffer and restart fetch at a new pc
//   inst_o, pc_o, valid_o,       head entry to the decoder; valid_o&ready_i pops
//   ready_i
//   ar*_o / arready_i            AXI read-address channel
//   r*_i / rready_o              AXI read-data channel (rid_i is ignored)
//   err_o                        sticky fetch error
//
// Optional feature: define IFU_PREFETCH_RRESP_CHECK_EN to act on rresp_i.
// An error beat is then dropped, err_o sets until reset, and fetching stops.
// Without the macro rresp_i is ignored and err_o stays 0.
module ifu_prefetch #(
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] RESET_PC  = 32'h3000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [3:0]  arid_o,
   output logic [31:0] araddr_o,
   output logic [7:0]  arlen_o,
   output logic [2:0]  arsize_o,
   output logic [1:0]  arburst_o,
   output logic        arvalid_o,
   input  logic        arready_i,
   input  logic [3:0]  rid_i,
   input  logic [31:0] rdata_i,
   input  logic [1:0]  rresp_i,
   input  logic        rlast_i,
   input  logic        rvalid_i,
   output logic        rready_o,
   output logic        err_o
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN} state_e;

   state_e        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   ar_addr_q, ar_addr_d;
   logic [7:0]    ar_len_q, ar_len_d;
   logic          drain_q, drain_d;   // redirect arrived while AR still pending
   logic          err_q, err_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];

   logic [31:0]   off, beats;
   logic [CW-1:0] free;
   logic          beat, push, pop, bad_beat;

`ifdef IFU_PREFETCH_RRESP_CHECK_EN
   assign bad_beat = rresp_i[1];
   logic unused_rsp;
   assign unused_rsp = ^{rid_i, rresp_i[0]};
`else
   assign bad_beat = 1'b0;
   logic unused_rsp;
   assign unused_rsp = ^{rid_i, rresp_i};
`endif

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Beats left before the next BURST_LEN*4-byte boundary.
   assign off   = (fetch_pc_q >> 2) & (BURST_LEN - 1);
   assign beats = BURST_LEN - off;
   assign free  = CW'(DEPTH) - count_q;

   assign arid_o    = 4'd0;
   assign arsize_o  = 3'b010;
   assign arburst_o = 2'b01;
   assign arvalid_o = (state_q == S_REQ);
   assign araddr_o  = arvalid_o ? ar_addr_q : 32'd0;
   assign arlen_o   = arvalid_o ? ar_len_q : 8'd0;
   assign rready_o  = (state_q == S_DATA) || (state_q == S_DRAIN);
   assign err_o     = err_q;

   assign valid_o = (count_q != '0);
   assign inst_o  = valid_o ? inst_mem_q[rd_ptr_q] : 32'd0;
   assign pc_o    = valid_o ? pc_mem_q[rd_ptr_q] : 32'd0;

   assign beat = rvalid_i & rready_o;
   // A redirect flushes, so neither a push nor a pop survives it.
   assign push = (state_q == S_DATA) && beat && !redirect_i && !bad_beat && !err_q;
   assign pop  = valid_o && ready_i && !redirect_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      drain_d    = drain_q;
      err_d      = err_q;
      unique case (state_q)
         // Space for the whole burst is reserved up front, so push never overflows.
         S_IDLE: if (!redirect_i && !err_q && (32'(free) >= beats)) begin
            state_d   = S_REQ;
            ar_addr_d = fetch_pc_q;
            ar_len_d  = 8'(beats - 1);
            drain_d   = 1'b0;
         end
         // The address is latched, so a redirect cannot disturb a pending AR.
         S_REQ: begin
            if (arready_i) state_d = (drain_q || redirect_i) ? S_DRAIN : S_DATA;
            else if (redirect_i) drain_d = 1'b1;
         end
         S_DATA: begin
            if (push) fetch_pc_d = fetch_pc_q + 32'd4;
            if (beat && !redirect_i && bad_beat) err_d = 1'b1;
            if (beat && rlast_i) state_d = S_IDLE;
            else if (redirect_i) state_d = S_DRAIN;
         end
         S_DRAIN: if (beat && rlast_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (redirect_i) fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= {RESET_PC[31:2], 2'b00};
         ar_addr_q  <= 32'd0;
         ar_len_q   <= 8'd0;
         drain_q    <= 1'b0;
         err_q      <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         drain_q    <= drain_d;
         err_q      <= err_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         inst_mem_q[wr_ptr_q] <= rdata_i;
      end
   end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: an AXI read slave returning addr-derived data two
// cycles after each AR, plus a scoreboard of expected {pc, inst} entries.
module tb_ifu_prefetch;
   localparam logic [31:0] RST_PC = 32'h3000_0000;

   logic        clk, rst_i, redirect_i, ready_i, arready_i;
   logic [31:0] redirect_pc_i, inst_o, pc_o, araddr_o, rdata_i;
   logic        valid_o, arvalid_o, rlast_i, rvalid_i, rready_o, err_o;
   logic [3:0]  arid_o, rid_i;
   logic [7:0]  arlen_o;
   logic [2:0]  arsize_o;
   logic [1:0]  arburst_o, rresp_i;

   ifu_prefetch #(.BURST_LEN(4), .DEPTH(8), .RESET_PC(RST_PC)) dut (
      .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .inst_o(inst_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
      .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
      .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
      .rvalid_i(rvalid_i), .rready_o(rready_o), .err_o(err_o));

   typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
   typedef struct {logic [31:0] addr; int left; int beat; int wait_cnt; bit stale;} burst_t;
   typedef struct {logic [31:0] pc; int delay; logic [7:0] len;} vec_t;

   int checks = 0, errors = 0;
   int good_ar = 0, total_ar = 0, pops = 0, discards = 0;
   exp_t        exp_q[$];
   burst_t      bursts[$];
   logic [31:0] pop_log[$];
   logic [31:0] exp_pc = RST_PC, ar_hold = 0, last_ar_addr = 0, bad_addr = 32'hFFFF_FFF0;
   logic [7:0]  len_hold = 0, last_ar_len = 0;
   bit          ar_stale = 0, ar_prev = 0, err_model = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] dat(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
   endfunction

   function automatic logic [7:0] exp_len(input logic [31:0] a);
      return 8'(3 - ((a >> 2) & 32'd3));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Slave driver: presents the front burst's next beat just after each edge.
   initial begin
      burst_t b;
      rvalid_i = 0; rdata_i = 0; rlast_i = 0; rresp_i = 0; rid_i = 0;
      forever begin
         @(posedge clk); #1;
         rvalid_i = 1'b0;
         if (bursts.size() != 0) begin
            b = bursts[0];
            if (b.wait_cnt > 0) begin
               b.wait_cnt--;
               bursts[0] = b;
            end else begin
               rvalid_i = 1'b1;
               rdata_i  = dat(b.addr);
               rlast_i  = (b.left == 1);
               rresp_i  = (b.addr == bad_addr) ? 2'b10 : 2'b00;
               rid_i    = 4'($urandom);
            end
         end
      end
   end

   // Scoreboard: at the falling edge, predicts what the next rising edge does.
   initial begin
      burst_t b;
      exp_t   e;
      forever begin
         @(negedge clk);
         chk("err_o", {31'b0, err_o}, {31'b0, err_model});
         if (rst_i) begin
            exp_q.delete(); bursts.delete();
            exp_pc = RST_PC; ar_stale = 0; ar_prev = 0; err_model = 0;
         end else begin
            if (valid_o && ready_i && !redirect_i) begin
               pops++;
               if (exp_q.size() == 0) fail("pop_unexpected");
               else begin
                  e = exp_q.pop_front();
                  chk("pc_o", pc_o, e.pc);
                  chk("inst_o", inst_o, e.inst);
                  pop_log.push_back(pc_o);
               end
            end
            if (rvalid_i && rready_o) begin
               if (bursts.size() == 0) fail("beat_without_burst");
               else begin
                  b = bursts[0];
                  if (b.stale || redirect_i) discards++;
`ifdef IFU_PREFETCH_RRESP_CHECK_EN
                  else if (err_model || rresp_i[1]) err_model = 1'b1;
`endif
                  else begin
                     e.pc = b.addr; e.inst = dat(b.addr);
                     exp_q.push_back(e);
                     exp_pc = b.addr + 32'd4;
                  end
                  b.addr += 32'd4; b.left--; b.beat++;
                  if (b.left == 0) void'(bursts.pop_front());
                  else bursts[0] = b;
               end
            end
            if (arvalid_o) begin
               if (!ar_prev) begin
                  chk("araddr_o", araddr_o, exp_pc);
                  chk("arlen_o", {24'b0, arlen_o}, {24'b0, exp_len(exp_pc)});
                  ar_hold = araddr_o; len_hold = arlen_o;
               end else begin
                  chk("araddr_stable", araddr_o, ar_hold);
                  chk("arlen_stable", {24'b0, arlen_o}, {24'b0, len_hold});
               end
               if (arready_i) begin
                  b.addr = araddr_o; b.left = int'(arlen_o) + 1; b.beat = 0;
                  b.wait_cnt = 2; b.stale = ar_stale || redirect_i;
                  bursts.push_back(b);
                  total_ar++;
                  if (!b.stale) begin
                     good_ar++; last_ar_addr = araddr_o; last_ar_len = arlen_o;
                  end
                  ar_stale = 0;
               end else if (redirect_i) ar_stale = 1;
            end else begin
               chk("araddr_idle", araddr_o, 32'd0);
            end
            ar_prev = arvalid_o && !arready_i;
            if (redirect_i) begin
               exp_q.delete();
               for (int i = 0; i < bursts.size(); i++) begin
                  b = bursts[i]; b.stale = 1'b1; bursts[i] = b;
               end
               exp_pc = {redirect_pc_i[31:2], 2'b00};
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #2;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_i = 1'b1; redirect_pc_i = pc;
      pop_log.delete();
      cyc();
      redirect_i = 1'b0;
   endtask

   task automatic wait_good(input int target);
      for (int i = 0; i < 300; i++) begin
         if (good_ar >= target) return;
         cyc();
      end
      fail("ar_timeout");
   endtask

   task automatic chk_log(input int idx, input logic [31:0] req);
      if (pop_log.size() > idx) chk("pop_pc_seq", pop_log[idx], req);
      else fail("pop_pc_missing");
   endtask

   task automatic chk_reset_outs();
      chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
      chk("rst_arvalid_o", {31'b0, arvalid_o}, 32'd0);
      chk("rst_rready_o", {31'b0, rready_o}, 32'd0);
      chk("rst_err_o", {31'b0, err_o}, 32'd0);
      chk("rst_pc_o", pc_o, 32'd0);
      chk("rst_inst_o", inst_o, 32'd0);
      chk("rst_araddr_o", araddr_o, 32'd0);
      chk("rst_arlen_o", {24'b0, arlen_o}, 32'd0);
   endtask

   vec_t vecs[5];
   int   base, d0, t0;
   logic [31:0] a0;

   initial begin
      vecs[0] = '{32'h3000_0008, 0, 8'd1};
      vecs[1] = '{32'h3000_0004, 3, 8'd2};
      vecs[2] = '{32'h3000_000C, 1, 8'd0};
      vecs[3] = '{32'h4000_0010, 2, 8'd3};
      vecs[4] = '{32'h3000_0020, 5, 8'd3};

      rst_i = 1; redirect_i = 0; redirect_pc_i = 0; ready_i = 1; arready_i = 1;
      repeat (3) cyc();
      chk_reset_outs();
      chk("arid_o", {28'b0, arid_o}, 32'd0);
      chk("arsize_o", {29'b0, arsize_o}, 32'd2);
      chk("arburst_o", {30'b0, arburst_o}, 32'd1);
      rst_i = 0;

      // First burst after reset.
      wait_good(1);
      chk("first_araddr", last_ar_addr, 32'h3000_0000);
      chk("first_arlen", {24'b0, last_ar_len}, 32'd3);
      repeat (10) cyc();
      for (int i = 0; i < 4; i++) chk_log(i, 32'h3000_0000 + 32'(4 * i));

      // Redirect vectors: boundary-limited burst lengths.
      foreach (vecs[i]) begin
         repeat (vecs[i].delay) cyc();
         base = good_ar;
         do_redirect(vecs[i].pc);
         wait_good(base + 1);
         chk("vec_araddr", last_ar_addr, vecs[i].pc);
         chk("vec_arlen", {24'b0, last_ar_len}, {24'b0, vecs[i].len});
         repeat (16) cyc();
         chk_log(0, vecs[i].pc);
         chk_log(1, vecs[i].pc + 32'd4);
      end

      // Redirect while the second beat of a 4-beat burst is on the bus.
      base = good_ar;
      do_redirect(32'h3000_0100);
      wait_good(base + 1);
      begin : find_beat2
         for (int i = 0; i < 100; i++) begin
            if (rvalid_i && bursts.size() != 0 && bursts[0].beat == 1 &&
                bursts[0].left == 3 && !bursts[0].stale) disable find_beat2;
            cyc();
         end
         fail("beat2_not_found");
      end
      d0 = discards; base = good_ar;
      do_redirect(32'h3000_0200);
      wait_good(base + 1);
      chk("drain_araddr", last_ar_addr, 32'h3000_0200);
      chk("drain_discards", 32'(discards - d0), 32'd3);

      // Redirect while AR is stalled by arready_i=0.
      arready_i = 0;
      begin : find_ar
         for (int i = 0; i < 100; i++) begin
            if (arvalid_o) disable find_ar;
            cyc();
         end
         fail("arvalid_not_seen");
      end
      a0 = araddr_o; base = good_ar;
      do_redirect(32'h3000_0304);
      repeat (3) cyc();
      chk("ar_held_valid", {31'b0, arvalid_o}, 32'd1);
      chk("ar_held_addr", araddr_o, a0);
      arready_i = 1;
      wait_good(base + 1);
      chk("post_stall_araddr", last_ar_addr, 32'h3000_0304);
      chk("post_stall_arlen", {24'b0, last_ar_len}, 32'd2);

      // Back-pressure: two bursts fill the buffer, the third waits for 4 pops.
      ready_i = 0;
      base = good_ar;
      do_redirect(32'h3000_0400);
      repeat (40) cyc();
      chk("bp_two_bursts", 32'(good_ar - base), 32'd2);
      chk("bp_valid_held", {31'b0, valid_o}, 32'd1);
      chk("bp_head_pc", pc_o, 32'h3000_0400);
      chk("bp_entries", 32'(exp_q.size()), 32'd8);
      ready_i = 1; repeat (3) cyc(); ready_i = 0;
      repeat (10) cyc();
      chk("bp_no_third_ar", 32'(good_ar - base), 32'd2);
      ready_i = 1; cyc(); ready_i = 0;
      repeat (12) cyc();
      chk("bp_third_ar", 32'(good_ar - base), 32'd3);

      // Error response on beat 3 of an aligned burst.
      base = good_ar;
      bad_addr = 32'h3000_0508;
      do_redirect(32'h3000_0500);
      repeat (40) cyc();
`ifdef IFU_PREFETCH_RRESP_CHECK_EN
      chk("err_set", {31'b0, err_o}, 32'd1);
      chk("err_entries", 32'(exp_q.size()), 32'd2);
      chk("err_one_burst", 32'(good_ar - base), 32'd1);
      t0 = total_ar;
      repeat (15) cyc();
      chk("err_no_more_ar", 32'(total_ar - t0), 32'd0);
`else
      chk("rresp_ignored_err", {31'b0, err_o}, 32'd0);
      chk("rresp_ignored_entries", 32'(exp_q.size()), 32'd8);
      chk("rresp_ignored_bursts", 32'(good_ar - base), 32'd2);
`endif
      bad_addr = 32'hFFFF_FFF0;
      ready_i = 1;

      // Reset mid-burst abandons the transaction.
      begin : find_rbeat
         for (int i = 0; i < 30; i++) begin
            if (rvalid_i) disable find_rbeat;
            cyc();
         end
      end
      rst_i = 1;
      repeat (2) cyc();
      chk_reset_outs();
      rst_i = 0;
      base = good_ar;
      wait_good(base + 1);
      chk("rst_again_araddr", last_ar_addr, RST_PC);
      chk("rst_again_arlen", {24'b0, last_ar_len}, 32'd3);
      repeat (12) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
